// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared constants and repeat FSM encoding for board input conditioning
package board_io_pkg;

    localparam int DEBOUNCE_1MS        = 100_000;
    localparam int REPEAT_DELAY_500MS  = 50_000_000;
    localparam int REPEAT_PERIOD_100MS = 10_000_000;

    localparam int BTN_CENTER = 0;
    localparam int BTN_UP     = 1;
    localparam int BTN_RIGHT  = 2;
    localparam int BTN_LEFT   = 3;
    localparam int BTN_DOWN   = 4;

    typedef enum logic [1:0] {
        RPT_IDLE = 2'd0,
        RPT_HOLD = 2'd1,
        RPT_RPT  = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - raw input and conditioned event bundle
interface input_conditioner_if #(
    parameter int N = 5
);
    logic [N-1:0] raw_in_i;
    logic [N-1:0] level_o;
    logic [N-1:0] press_o;
    logic [N-1:0] release_o;
    logic [N-1:0] rpt_o;

    modport master (
        output raw_in_i,
        input  level_o,
        input  press_o,
        input  release_o,
        input  rpt_o
    );

    modport slave (
        input  raw_in_i,
        output level_o,
        output press_o,
        output release_o,
        output rpt_o
    );
endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one input: synchronizer, debounce, edge pulses, hold-to-repeat
module debounce_channel
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS,
    parameter bit RPT_EN          = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic rpt_o
);

    localparam int CW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DW  = $clog2(REPEAT_DELAY);
    localparam int PW  = $clog2(REPEAT_PERIOD);
    localparam int RW0 = (DW > PW) ? DW : PW;
    localparam int RW  = (RW0 > 0) ? RW0 : 1;

    logic          s1_q, s2_q;
    logic          level_q, press_q, release_q, rpt_q, rpt_d;
    logic [CW-1:0] cnt_q;
    logic [RW-1:0] rcnt_q, rcnt_d;
    rpt_state_e    state_q, state_d;
    logic          accept, rise_d, fall_d;

    // The repeat FSM reacts to the accepted edge on the same clock that press/release register,
    // so the first repeat lands exactly REPEAT_DELAY cycles after the press pulse.
    assign accept = (s2_q != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    assign rise_d = accept & s2_q;
    assign fall_d = accept & ~s2_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rpt_q     <= 1'b0;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            state_q   <= RPT_IDLE;
        end else begin
            s1_q      <= raw_i;
            s2_q      <= s1_q;
            press_q   <= rise_d;
            release_q <= fall_d;
            rpt_q     <= rpt_d;
            rcnt_q    <= rcnt_d;
            state_q   <= state_d;
            if (s2_q == level_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                level_q <= s2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rpt_d   = 1'b0;
        if (RPT_EN) begin
            case (state_q)
                RPT_IDLE: begin
                    if (rise_d) begin
                        state_d = RPT_HOLD;
                        rcnt_d  = '0;
                    end
                end
                RPT_HOLD: begin
                    if (fall_d) begin
                        state_d = RPT_IDLE;
                    end else if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
                        rpt_d   = 1'b1;
                        rcnt_d  = '0;
                        state_d = RPT_RPT;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                RPT_RPT: begin
                    if (fall_d) begin
                        state_d = RPT_IDLE;
                    end else if (rcnt_q == RW'(REPEAT_PERIOD - 1)) begin
                        rpt_d  = 1'b1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                default: state_d = RPT_IDLE;
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign rpt_o     = rpt_q;

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - N independent debounced channels with per-channel autorepeat
module input_conditioner
    import board_io_pkg::*;
#(
    parameter int           N               = 5,
    parameter int           DEBOUNCE_CYCLES = DEBOUNCE_1MS,
    parameter int           REPEAT_DELAY    = REPEAT_DELAY_500MS,
    parameter int           REPEAT_PERIOD   = REPEAT_PERIOD_100MS,
    parameter logic [N-1:0] RPT_MASK        = N'((1 << BTN_LEFT) | (1 << BTN_RIGHT))
) (
    input logic                clk,
    input logic                reset,
    input_conditioner_if.slave io
);

    logic [N-1:0] level_w, press_w, release_w, rpt_w;

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .RPT_EN         (RPT_MASK[i])
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .raw_i    (io.raw_in_i[i]),
            .level_o  (level_w[i]),
            .press_o  (press_w[i]),
            .release_o(release_w[i]),
            .rpt_o    (rpt_w[i])
        );
    end

    assign io.level_o   = level_w;
    assign io.press_o   = press_w;
    assign io.release_o = release_w;
    assign io.rpt_o     = rpt_w;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed and random checks of input_conditioner against a history-based model
module tb_input_conditioner;

    localparam int         N    = 5;
    localparam int         D    = 4;
    localparam int         RD   = 10;
    localparam int         RP   = 3;
    localparam logic [4:0] MASK = 5'b01100;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0] raw;

    input_conditioner_if #(.N(N)) bus ();
    assign bus.raw_in_i = raw;

    input_conditioner #(
        .N              (N),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .RPT_MASK       (MASK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: a level is accepted once the last D synchronized samples all disagree with it;
    // repeats fall at press_time + RD + k*RP while the level stays high.
    logic [N-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_rpt;
    logic [D-1:0] m_hist [N];
    int           m_pt   [N];

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_level = '0;
            m_press = '0; m_rel = '0; m_rpt = '0;
            for (int c = 0; c < N; c++) begin
                m_hist[c] = '0;
                m_pt[c]   = -1;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                m_hist[c]  = {m_hist[c][D-2:0], m_s2[c]};
                m_press[c] = 1'b0;
                m_rel[c]   = 1'b0;
                m_rpt[c]   = 1'b0;
                if (m_hist[c] == {D{~m_level[c]}}) begin
                    m_level[c] = ~m_level[c];
                    if (m_level[c]) begin
                        m_press[c] = 1'b1;
                        m_pt[c]    = cyc;
                    end else begin
                        m_rel[c] = 1'b1;
                        m_pt[c]  = -1;
                    end
                end
                if (MASK[c] && m_pt[c] >= 0 && (cyc - m_pt[c]) >= RD
                    && ((cyc - m_pt[c] - RD) % RP) == 0)
                    m_rpt[c] = 1'b1;
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("level",   bus.level_o,   m_level);
        check("press",   bus.press_o,   m_press);
        check("release", bus.release_o, m_rel);
        check("rpt",     bus.rpt_o,     m_rpt);
    endtask

    int t0, pcyc, nrpt, npress, nrpt0, rate;

    initial begin
        reset = 1'b0;
        raw   = '0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();

        // Clean press on channel 2, hold into autorepeat, release on a repeat expiry
        raw[2] = 1'b1;
        tick();
        t0 = cyc; pcyc = -1; nrpt = 0;
        while (cyc < t0 + 5 + 10) begin
            tick();
            if (bus.press_o[2] && pcyc < 0) pcyc = cyc;
            if (bus.rpt_o[2]) nrpt++;
        end
        check_int("press_latency", pcyc - t0, 5);
        raw[2] = 1'b0;
        repeat (5) begin
            tick();
            if (bus.rpt_o[2]) nrpt++;
        end
        check_int("rpt_count_before_release", nrpt, 2);
        tick();
        check_int("release_at_expiry", int'(bus.release_o[2]), 1);
        check_int("no_rpt_at_release", int'(bus.rpt_o[2]), 0);
        repeat (10) tick();

        // Bounce on channel 3
        for (int b = 0; b < 2; b++) begin
            raw[3] = 1'b1; repeat (2) tick();
            raw[3] = 1'b0; repeat (2) tick();
        end
        raw[3] = 1'b1;
        repeat (20) tick();
        raw[3] = 1'b0;
        repeat (10) tick();

        // Masked channel 0 held for 40 cycles
        raw[0] = 1'b1; npress = 0; nrpt0 = 0;
        repeat (40) begin
            tick();
            if (bus.press_o[0]) npress++;
            if (bus.rpt_o[0]) nrpt0++;
        end
        check_int("masked_press_once", npress, 1);
        check_int("masked_no_rpt", nrpt0, 0);
        raw[0] = 1'b0;
        repeat (10) tick();

        // Reset mid-debounce, input held through reset release
        raw[2] = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check_int("reset_clears_level", int'(bus.level_o), 0);
        reset = 1'b1;
        tick();
        t0 = cyc; pcyc = -1;
        repeat (8) begin
            tick();
            if (bus.press_o[2] && pcyc < 0) pcyc = cyc;
        end
        check_int("press_after_reset_debounce", pcyc - t0, 5);

        // Reset mid-repeat
        repeat (14) tick();
        reset = 1'b0;
        tick();
        check_int("reset_clears_rpt_level", int'(bus.level_o[2]), 0);
        reset = 1'b1;
        tick();
        t0 = cyc; pcyc = -1;
        repeat (8) begin
            tick();
            if (bus.press_o[2] && pcyc < 0) pcyc = cyc;
        end
        check_int("press_after_reset_rpt", pcyc - t0, 5);
        raw[2] = 1'b0;
        repeat (10) tick();

        // Simultaneous rise on channels 2 and 3
        raw[2] = 1'b1; raw[3] = 1'b1;
        tick();
        t0 = cyc; pcyc = -1;
        repeat (8) begin
            tick();
            if (bus.press_o[3:2] == 2'b11 && pcyc < 0) pcyc = cyc;
        end
        check_int("simultaneous_press", pcyc - t0, 5);
        raw = '0;
        repeat (10) tick();

        // Random stimulus with varying toggle rates and rare resets
        rate = 4;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rate = 2;
                    1:       rate = 6;
                    default: rate = 30;
                endcase
            end
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, rate - 1) == 0) raw[c] = ~raw[c];
            reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        reset = 1'b1;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Cleans raw asynchronous board inputs (push-buttons, slide switches) into glitch-free levels and single-cycle event pulses for the display/control logic downstream. Each channel gets a 2-FF synchronizer, a debounce counter, press/release edge pulses, and an optional hold-to-repeat generator. The display top consumes `press` for left/right shifts and rising edges of the switch channels for mode changes, replacing its local raw-input delay chains.

## Interface
- `N`, 5: number of input channels.
- `DEBOUNCE_CYCLES`, 100000: consecutive stable cycles required to accept a new level (1 ms at 100 MHz). Must be ≥ 2.
- `REPEAT_DELAY`, 50000000: hold cycles before the first repeat pulse.
- `REPEAT_PERIOD`, 10000000: cycles between subsequent repeat pulses.
- `RPT_MASK`, 5'b01100: per-channel autorepeat enable. Default is left (3) and right (2) buttons.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: reset, synchronous, active-low.
- `raw_in` in N: asynchronous raw inputs, active-high.
- `level` out N: debounced level.
- `press` out N: one-cycle pulse on each accepted 0→1 of `level`.
- `release` out N: one-cycle pulse on each accepted 1→0 of `level`.
- `rpt` out N: one-cycle autorepeat pulse. Always 0 for channels with `RPT_MASK` bit clear.

## Operation
- **Reset** (`reset`=0 at a clk edge): all sync flops, counters and outputs go to 0, and every FSM returns to IDLE. Reset mid-debounce or mid-repeat discards the progress.
- **Synchronizer:** `s1 <= raw_in`, then `s2 <= s1`. Only `s2` is used downstream.
- **Debounce, per channel:**
  - While `s2 == level`, `cnt` is held at 0.
  - While `s2 != level`, `cnt` increments by 1 per cycle.
  - On the edge where the mismatch persists and `cnt == DEBOUNCE_CYCLES-1`, `level` flips and `cnt` clears.
  - Any cycle with `s2 == level` clears `cnt`, so glitches shorter than `DEBOUNCE_CYCLES` are fully rejected.
- **Edge pulses:** `press` and `release` are registered and asserted in the same cycle that the new `level` first appears. They are never asserted together on one channel.
- **Repeat FSM, per channel with `RPT_MASK` bit set:**
  - IDLE → HOLD when `press` is asserted; `rcnt` clears.
  - HOLD: `rcnt` increments. When `rcnt == REPEAT_DELAY-1`, assert `rpt`, clear `rcnt`, go to RPT.
  - RPT: `rcnt` increments. When `rcnt == REPEAT_PERIOD-1`, assert `rpt` and clear `rcnt`.
  - HOLD or RPT → IDLE when `release` is asserted. This takes priority over a coinciding expiry, so no `rpt` is issued that cycle.
- **Counter widths:** `$clog2` of the respective parameter. Counters never wrap, because the compare clears them first.
- **Channels are fully independent.** Simultaneous events on different channels each produce their own pulses in the same cycle.
- **Input held through reset release:** it is treated as a new press. `level` rises and `press` fires after the normal latency.

## Timing
- Let edge k be the clk edge at which `s1` first captures a new stable raw value.
- `level`, `press` and `release` update at edge k+1+`DEBOUNCE_CYCLES`.
- First `rpt` comes `REPEAT_DELAY` cycles after the `press` cycle. Subsequent `rpt` pulses come every `REPEAT_PERIOD` cycles.
- All outputs are registered, with no combinational path from `raw_in`.
- Pulse width is exactly 1 cycle.

## Structure
- **Package `board_io_pkg`:**
  - Default parameter constants: `DEBOUNCE_1MS`, `REPEAT_DELAY_500MS`, `REPEAT_PERIOD_100MS`.
  - Button index constants: `BTN_RIGHT`=2, `BTN_LEFT`=3 (remaining indices per board pinout).
  - Repeat FSM state encoding: IDLE, HOLD, RPT.
- **Sub-module `debounce_channel`:** one channel containing synchronizer, debounce counter, edge pulses and repeat FSM, with a `RPT_EN` parameter. `input_conditioner` instantiates it N times in a generate loop.
- **Instances in top:** one for `BTN[4:0]`, and one for the switches with `RPT_MASK`=0.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, N=5.
- **Clean press:** `raw_in[2]` rises and is captured by `s1` at edge 0 → `level[2]`=1 and `press[2]`=1 at edge 5 only; `press[2]`=0 at edge 6.
- **Bounce:** `raw_in[3]` toggles 1,0,1,0 every 2 cycles, then holds 1 → no `press` during bouncing; a single `press[3]` appears 5 edges after the final rise is captured.
- **Autorepeat:** hold `raw_in[2]` → `rpt[2]` at `press`+10, +13, +16. Release → `release[2]` with no further `rpt`. A release coinciding with expiry emits no `rpt`.
- **Masked channel:** hold `raw_in[0]` for 40 cycles → `press[0]` once, `rpt[0]` stays 0.
- **Reset:** assert `reset`=0 mid-debounce and mid-RPT → all outputs 0 the next cycle. With `raw_in[2]` still high after release, `press[2]` fires 5 edges after the first capture.
- **Simultaneous:** `raw_in[2]` and `raw_in[3]` rise on the same cycle → both `press` bits assert in the same cycle.
